// File: rtl/serial_col_pkg.sv
// Shared definitions for the serial column link (scheduler side and serial_in receiver).
package serial_col_pkg;
    localparam int COL_W    = 3;
    localparam int NUM_COLS = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        GAPW  = 2'd3
    } state_t;
endpackage

// File: rtl/serial_col_sched_if.sv
// Requester/scheduler bus: two request/column pairs in, grant, status and serial pins out.
interface serial_col_sched_if #(parameter int COL_W = serial_col_pkg::COL_W);
    logic             req0;
    logic [COL_W-1:0] col0;
    logic             req1;
    logic [COL_W-1:0] col1;
    logic [1:0]       gnt;
    logic             busy;
    logic             done;
    logic             ser_clk;
    logic             ser_bit;

    modport master (output req0, col0, req1, col1,
                    input  gnt, busy, done, ser_clk, ser_bit);
    modport slave  (input  req0, col0, req1, col1,
                    output gnt, busy, done, ser_clk, ser_bit);
endinterface

// File: rtl/serial_col_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to favour the loser after each grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic ptr_r;

    // ptr_r = 0 favours req[0], ptr_r = 1 favours req[1]
    assign gnt[0] = req[0] & (~req[1] | ~ptr_r);
    assign gnt[1] = req[1] & (~req[0] |  ptr_r);

    // Pointer update: after granting requester 0, favour requester 1 and vice versa
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= 1'b0;
        end else if (advance) begin
            ptr_r <= gnt[0];
        end else begin
            ptr_r <= ptr_r;
        end
    end
endmodule

// File: rtl/serial_col_sched.sv
// Arbitrates two column-index requesters and shifts the winner's index out LSB-first
// with a divided serial clock, followed by a guard gap.
module serial_col_sched
    import serial_col_pkg::*;
#(
    parameter int DIV = 4,
    parameter int GAP = 8
) (
    input  logic              clk,
    input  logic              reset,
    serial_col_sched_if.slave bus
);
    localparam int TMAX = (DIV > GAP) ? DIV : GAP;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int BW   = $clog2(COL_W + 1);

    state_t           state_r;
    logic [TW-1:0]    timer_r;
    logic [BW-1:0]    bit_cnt_r;
    logic [COL_W-1:0] shreg_r;
    logic             busy_r;
    logic             done_r;
    logic             ser_clk_r;
    logic             ser_bit_r;

    logic             idle_s;
    logic [1:0]       req_s;
    logic [1:0]       gnt_s;
    logic [COL_W-1:0] shift_s;

    // Grants are only possible in IDLE and never while reset is asserted
    assign idle_s  = (state_r == IDLE) && reset;
    assign req_s   = {bus.req1, bus.req0} & {2{idle_s}};
    assign shift_s = shreg_r >> 1;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_s),
        .advance (|gnt_s),
        .gnt     (gnt_s)
    );

    assign bus.gnt     = gnt_s;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.ser_clk = ser_clk_r;
    assign bus.ser_bit = ser_bit_r;

    // Frame FSM: output flops are loaded with the levels of the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            timer_r   <= '0;
            bit_cnt_r <= '0;
            shreg_r   <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ser_clk_r <= 1'b0;
            ser_bit_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    timer_r   <= '0;
                    bit_cnt_r <= '0;
                    done_r    <= 1'b0;
                    ser_clk_r <= 1'b0;
                    if (|gnt_s) begin
                        state_r   <= SETUP;
                        shreg_r   <= gnt_s[1] ? bus.col1 : bus.col0;
                        ser_bit_r <= gnt_s[1] ? bus.col1[0] : bus.col0[0];
                        busy_r    <= 1'b1;
                    end else begin
                        busy_r    <= 1'b0;
                        ser_bit_r <= 1'b0;
                    end
                end
                SETUP: begin
                    if (timer_r == TW'(DIV - 1)) begin
                        state_r   <= HIGH;
                        timer_r   <= '0;
                        ser_clk_r <= 1'b1;
                    end else begin
                        timer_r   <= timer_r + TW'(1);
                    end
                end
                HIGH: begin
                    if (timer_r == TW'(DIV - 1)) begin
                        timer_r   <= '0;
                        shreg_r   <= shift_s;
                        bit_cnt_r <= bit_cnt_r + BW'(1);
                        ser_clk_r <= 1'b0;
                        if (bit_cnt_r == BW'(COL_W - 1)) begin
                            state_r   <= GAPW;
                            ser_bit_r <= 1'b0;
                            done_r    <= (GAP == 1);
                        end else begin
                            state_r   <= SETUP;
                            ser_bit_r <= shift_s[0];
                        end
                    end else begin
                        timer_r   <= timer_r + TW'(1);
                    end
                end
                GAPW: begin
                    if (timer_r == TW'(GAP - 1)) begin
                        state_r <= IDLE;
                        timer_r <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                        // done lands in the final gap cycle
                        done_r  <= (timer_r == TW'(GAP - 2));
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    timer_r   <= '0;
                    bit_cnt_r <= '0;
                    shreg_r   <= '0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    ser_clk_r <= 1'b0;
                    ser_bit_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
